multiaddr_req_scheduler: RTL and testbench
==========================================

# multiaddr_req_scheduler

Sequencing controller for multi-address (multicast) requests. It accepts one request in {addr, mask} form over a valid/ready handshake and matches it against an address map of {addr, mask} rules. It then issues one downstream transaction per matched rule, in ascending rule index, each carrying the subset of the request that falls inside that rule. It sits between a multicast-capable requester and a rule-indexed interconnect port, and serialises one multi-address request into per-rule beats.

## Interface
- `NoRules`, default 1: number of address map rules; must be ≥1.
- `addr_t`, default `logic`: address type.
- `rule_t`, default `logic`: packed struct with fields `addr_t addr; addr_t mask;`.
- `IdxWidth`, default `(NoRules > 1) ? $clog2(NoRules) : 1`: derived, do not override.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Asynchronous and active-high.
- `addr_map_i` in `rule_t[NoRules]`: address map. Must be stable while `busy_o`=1.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_addr_i` in `addr_t`: request address.
- `req_mask_i` in `addr_t`: request mask. A 1 means "don't care".
- `mst_valid_o` out 1: downstream beat valid.
- `mst_ready_i` in 1: downstream beat ready.
- `mst_addr_o` out `addr_t`: beat address.
- `mst_mask_o` out `addr_t`: beat mask.
- `mst_idx_o` out `IdxWidth`: matched rule index.
- `mst_last_o` out 1: final beat of the current request.
- `err_o` out 1: one-cycle pulse when an accepted request matched no rule.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, ERR. Reset state is IDLE.
- `req_ready_o` = (state==IDLE). `busy_o` = (state!=IDLE).
- Rule `i` matches when `&((req_mask_i | rule[i].mask) | ~(req_addr_i ^ rule[i].addr))`.
- Accept (IDLE, `req_valid_i`&`req_ready_o`):
  - register `req_addr_i`, `req_mask_i` and the match vector into `pending`.
  - go to ISSUE if `pending`≠0, else go to ERR.
- ISSUE:
  - `mst_valid_o`=1.
  - `mst_idx_o` = lowest set bit of `pending`.
  - `mst_mask_o` = `q_mask & rule[idx].mask`.
  - `mst_addr_o` = `(~q_mask & q_addr) | (q_mask & rule[idx].addr)`.
  - `mst_last_o` = 1 when `pending` has exactly one bit set.
  - On handshake, clear `pending[idx]`; if `mst_last_o`=1, go to IDLE.
- ERR: `err_o`=1 for exactly one cycle, then go to IDLE.
- Outputs stay stable while `mst_valid_o`=1 and `mst_ready_i`=0. `mst_valid_o` never deasserts without a handshake, except on reset.
- Outside ISSUE, `mst_*` data outputs drive 0.
- `mst_ready_i` asserted outside ISSUE is ignored.

## Timing
- Reset values: `req_ready_o`=1, `mst_valid_o`=0, `mst_addr_o`/`mst_mask_o`/`mst_idx_o`=0, `mst_last_o`=0, `err_o`=0, `busy_o`=0, stat counters=0.
- Latency: a request accepted in cycle N presents its first beat in cycle N+1; `err_o` pulses in cycle N+1 instead when nothing matched.
- K matches with `mst_ready_i` held at 1 take K cycles in ISSUE. IDLE is reached in cycle N+K+1, and the next request can be accepted in that cycle.
- Minimum request period is therefore K+1 cycles, or 2 cycles for an error.
- `rst_i` asserted mid-operation:
  - immediately (asynchronously) forces IDLE, clears `pending`, and drops `mst_valid_o`/`err_o`.
  - the in-flight request is lost.
- All paths from request inputs to outputs are registered; no combinational `req_valid_i`→`mst_valid_o` path.
- `mst_addr_o`/`mst_mask_o` are combinational from registered state and `addr_map_i`.

## Configuration
- `MULTIADDR_REQ_SCHEDULER_STATS_EN` defined adds two outputs:
  - `stat_beats_o` [31:0]: +1 per downstream handshake.
  - `stat_errs_o` [31:0]: +1 per `err_o` pulse.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

## Test plan
Common setup: NoRules=4, 8-bit addr_t. Rules: r0 {0x00, 0x0F}, r1 {0x10, 0x0F}, r2 {0x20, 0x1F}, r3 {0x80, 0x7F}.
- Unicast: req {0x05, 0x00} → one beat {idx 0, 0x05, 0x00, last=1} in the cycle after accept; IDLE the next cycle.
- Multicast: req {0x00, 0x3F} → three beats in three cycles with ready high:
  - {0, 0x00, 0x0F}
  - {1, 0x10, 0x0F}
  - {2, 0x20, 0x1F, last=1}
  - `req_ready_o`=0 throughout.
- Backpressure: multicast case with `mst_ready_i` low for 3 cycles on beat idx1 → idx/addr/mask/last held stable, `pending` unchanged, beat idx2 follows the release.
- No match: req {0x40, 0x00} → `err_o`=1 for exactly one cycle, `mst_valid_o` stays 0, `req_ready_o`=1 two cycles after accept.
- Reset mid-request: `rst_i` pulsed during beat idx1 of the multicast case → `mst_valid_o`=0 in the same cycle; after release, `req_ready_o`=1 and a new unicast request issues normally.
- Stats (macro defined): multicast request followed by the no-match request → `stat_beats_o`=3, `stat_errs_o`=1.

Source files
------------

// File: rtl/multiaddr_req_scheduler.sv
// multiaddr_req_scheduler: accepts one {addr, mask} multicast request, matches it
// against an address map of {addr, mask} rules and issues one downstream beat per
// matching rule, lowest rule index first. A request matching no rule yields a
// one-cycle err_o pulse instead.
// Optional build macro MULTIADDR_REQ_SCHEDULER_STATS_EN adds beat/error counters.
module multiaddr_req_scheduler #(
    parameter int unsigned NoRules  = 1,
    parameter type         addr_t   = logic,
    parameter type         rule_t   = logic,
    parameter int unsigned IdxWidth = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  rule_t [NoRules-1:0] addr_map_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  addr_t               req_addr_i,
    input  addr_t               req_mask_i,
    output logic                mst_valid_o,
    input  logic                mst_ready_i,
    output addr_t               mst_addr_o,
    output addr_t               mst_mask_o,
    output logic [IdxWidth-1:0] mst_idx_o,
    output logic                mst_last_o,
    output logic                err_o,
    output logic                busy_o
`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
    ,
    output logic [31:0]         stat_beats_o,
    output logic [31:0]         stat_errs_o
`endif
);

    localparam int unsigned AW = $bits(addr_t);
    localparam int unsigned RW = $bits(rule_t);

    typedef enum logic [1:0] {IDLE, ISSUE, ERR} state_t;

    state_t               state_q, state_d;
    logic [NoRules-1:0]   pending_q, pending_d;
    addr_t                q_addr, q_mask;

    logic [NoRules*RW-1:0] map_flat;
    addr_t                 rule_addr [NoRules];
    addr_t                 rule_mask [NoRules];
    logic [NoRules-1:0]    match;

    logic                  found;
    logic [IdxWidth-1:0]   sel_idx;
    logic [NoRules-1:0]    sel_hot;
    addr_t                 sel_addr, sel_mask;
    logic                  last;
    logic                  accept;

    // Rules are packed {addr, mask}, so addr is the upper half of each rule;
    // slicing a flat copy keeps this legal for any rule_t, including scalars.
    assign map_flat = addr_map_i;

    // Split each rule into its fields and test the incoming request against it.
    always_comb begin
        rule_addr = '{default: '0};
        rule_mask = '{default: '0};
        match     = '0;
        for (int unsigned i = 0; i < NoRules; i++) begin
            rule_addr[i] = map_flat[i*RW + RW - 1 -: AW];
            rule_mask[i] = map_flat[i*RW + AW - 1 -: AW];
            match[i]     = &((req_mask_i | rule_mask[i]) | ~(req_addr_i ^ rule_addr[i]));
        end
    end

    // Pick the lowest pending rule as the beat currently on offer.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_hot  = '0;
        sel_addr = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < NoRules; i++) begin
            if (pending_q[i] && !found) begin
                found      = 1'b1;
                sel_idx    = IdxWidth'(i);
                sel_hot[i] = 1'b1;
                sel_addr   = rule_addr[i];
                sel_mask   = rule_mask[i];
            end
        end
    end

    assign last   = $onehot(pending_q);
    assign accept = (state_q == IDLE) && req_valid_i;

    // Next-state, pending update and output decode.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        mst_valid_o = 1'b0;
        mst_idx_o   = '0;
        mst_addr_o  = '0;
        mst_mask_o  = '0;
        mst_last_o  = 1'b0;
        err_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pending_d = match;
                    state_d   = (|match) ? ISSUE : ERR;
                end
            end
            ISSUE: begin
                mst_valid_o = 1'b1;
                mst_idx_o   = sel_idx;
                mst_mask_o  = q_mask & sel_mask;
                mst_addr_o  = (~q_mask & q_addr) | (q_mask & sel_addr);
                mst_last_o  = last;
                if (mst_ready_i) begin
                    pending_d = pending_q & ~sel_hot;
                    if (last) state_d = IDLE;
                end
            end
            ERR: begin
                err_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and captured request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            q_addr    <= '0;
            q_mask    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (accept) begin
                q_addr <= req_addr_i;
                q_mask <= req_mask_i;
            end
        end
    end

`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
    // Free-running beat and error counters, wrapping at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_beats_o <= '0;
            stat_errs_o  <= '0;
        end else begin
            if (mst_valid_o && mst_ready_i) stat_beats_o <= stat_beats_o + 32'd1;
            if (err_o)                      stat_errs_o  <= stat_errs_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multiaddr_req_scheduler.sv
// Self-checking bench for multiaddr_req_scheduler: directed test-plan scenarios
// plus randomized requests checked against a rule-level reference model.
module tb_multiaddr_req_scheduler;

    typedef logic [7:0] addr8_t;
    typedef struct packed { addr8_t addr; addr8_t mask; } rule8_t;
    localparam int unsigned NR = 4;

    logic               clk = 1'b0;
    logic               rst;
    rule8_t [NR-1:0]    addr_map;
    logic               req_valid, req_ready;
    addr8_t             req_addr, req_mask;
    logic               mst_valid, mst_ready;
    addr8_t             mst_addr, mst_mask;
    logic [1:0]         mst_idx;
    logic               mst_last, err, busy;
`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
    logic [31:0]        stat_beats, stat_errs;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Observation word: {req_ready, busy, err, mst_valid, mst_idx, mst_addr, mst_mask, mst_last}
    logic [22:0] obs;
    assign obs = {req_ready, busy, err, mst_valid, mst_idx, mst_addr, mst_mask, mst_last};
    localparam logic [22:0] IDLE_OBS = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};

    always #5 clk = ~clk;

    multiaddr_req_scheduler #(
        .NoRules (NR),
        .addr_t  (addr8_t),
        .rule_t  (rule8_t)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_map_i  (addr_map),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_mask_i  (req_mask),
        .mst_valid_o (mst_valid),
        .mst_ready_i (mst_ready),
        .mst_addr_o  (mst_addr),
        .mst_mask_o  (mst_mask),
        .mst_idx_o   (mst_idx),
        .mst_last_o  (mst_last),
        .err_o       (err),
        .busy_o      (busy)
`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
        ,
        .stat_beats_o(stat_beats),
        .stat_errs_o (stat_errs)
`endif
    );

    // Reference model: the list of beats a request should produce.
    logic [1:0] e_idx  [$];
    addr8_t     e_addr [$];
    addr8_t     e_mask [$];
    int unsigned m_beats, m_errs;

    task automatic model_req(input addr8_t a, input addr8_t m);
        e_idx.delete(); e_addr.delete(); e_mask.delete();
        for (int i = 0; i < NR; i++) begin
            addr8_t care;
            care = ~(m | addr_map[i].mask);
            if (((a ^ addr_map[i].addr) & care) == 8'h00) begin
                e_idx.push_back(2'(i));
                e_mask.push_back(m & addr_map[i].mask);
                e_addr.push_back((a & ~m) | (addr_map[i].addr & m));
            end
        end
    endtask

    task automatic set_default_map();
        addr_map[0] = '{addr: 8'h00, mask: 8'h0F};
        addr_map[1] = '{addr: 8'h10, mask: 8'h0F};
        addr_map[2] = '{addr: 8'h20, mask: 8'h1F};
        addr_map[3] = '{addr: 8'h80, mask: 8'h7F};
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL reset_state: got %b expected %b", obs, IDLE_OBS); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, IDLE_OBS); end
    endtask

    task automatic test_unicast();
        logic [22:0] exp;
        req_valid = 1'b1; req_addr = 8'h05; req_mask = 8'h00; mst_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 8'hAA; req_mask = 8'hFF;
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h05, 8'h00, 1'b1};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL unicast_beat: got %b expected %b", obs, exp); end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL unicast_idle: got %b expected %b", obs, IDLE_OBS); end
    endtask

    task automatic test_multicast(input int stall);
        logic [22:0] exp;
        req_valid = 1'b1; req_addr = 8'h00; req_mask = 8'h3F; mst_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 8'hFF; req_mask = 8'h00;
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h0F, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL mc_beat0 (stall %0d): got %b expected %b", stall, obs, exp); end
        @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h10, 8'h0F, 1'b0};
        for (int s = 0; s < stall; s++) begin
            mst_ready = 1'b0;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL mc_beat1_held cyc %0d: got %b expected %b", s, obs, exp); end
            @(negedge clk);
        end
        mst_ready = 1'b1;
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL mc_beat1 (stall %0d): got %b expected %b", stall, obs, exp); end
        @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'h20, 8'h1F, 1'b1};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL mc_beat2 (stall %0d): got %b expected %b", stall, obs, exp); end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL mc_idle (stall %0d): got %b expected %b", stall, obs, IDLE_OBS); end
    endtask

    task automatic test_no_match();
        logic [22:0] exp;
        req_valid = 1'b1; req_addr = 8'h40; req_mask = 8'h00; mst_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL nomatch_err: got %b expected %b", obs, exp); end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL nomatch_idle: got %b expected %b", obs, IDLE_OBS); end
    endtask

    task automatic test_reset_mid();
        logic [22:0] exp;
        req_valid = 1'b1; req_addr = 8'h00; req_mask = 8'h3F; mst_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h10, 8'h0F, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rstmid_beat1: got %b expected %b", obs, exp); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL rstmid_async: got %b expected %b", obs, IDLE_OBS); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL rstmid_release: got %b expected %b", obs, IDLE_OBS); end
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h9C; req_mask = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h9C, 8'h00, 1'b1};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rstmid_unicast: got %b expected %b", obs, exp); end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL rstmid_idle: got %b expected %b", obs, IDLE_OBS); end
    endtask

`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mst_ready = 1'b1;
        req_valid = 1'b1; req_addr = 8'h00; req_mask = 8'h3F;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h40; req_mask = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stat_beats !== 32'd3) begin n_fail++; $display("FAIL stat_beats: got %0d expected 3", stat_beats); end
        n_checks++;
        if (stat_errs !== 32'd1) begin n_fail++; $display("FAIL stat_errs: got %0d expected 1", stat_errs); end
    endtask
`endif

    // Random requests issued back-to-back with random backpressure, random
    // ignored ready outside ISSUE and periodic address-map changes while idle.
    task automatic test_random();
        logic [22:0] exp;
        addr8_t a, m;
        int     n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_beats = 0; m_errs = 0;
        for (int it = 0; it < 300; it++) begin
            if (it >= 100 && (it % 40) == 0) begin
                for (int i = 0; i < NR; i++) begin
                    addr_map[i].addr = 8'($urandom);
                    addr_map[i].mask = 8'($urandom) & 8'($urandom);
                end
            end
            a = 8'($urandom);
            m = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
            model_req(a, m);
            mst_ready = 1'($urandom);
            req_valid = 1'b1; req_addr = a; req_mask = m;
            @(negedge clk);
            req_valid = 1'b0; req_addr = 8'($urandom); req_mask = 8'($urandom);
            n = e_idx.size();
            if (n == 0) begin
                m_errs++;
                exp = {1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
                n_checks++;
                if (obs !== exp) begin n_fail++; $display("FAIL rand_err it %0d req %h/%h: got %b expected %b", it, a, m, obs, exp); end
                @(negedge clk);
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp = {1'b0, 1'b1, 1'b0, 1'b1, e_idx[k], e_addr[k], e_mask[k], (k == n - 1)};
                    for (int s = $urandom_range(0, 2); s > 0; s--) begin
                        mst_ready = 1'b0;
                        n_checks++;
                        if (obs !== exp) begin n_fail++; $display("FAIL rand_stall it %0d beat %0d: got %b expected %b", it, k, obs, exp); end
                        @(negedge clk);
                    end
                    mst_ready = 1'b1;
                    n_checks++;
                    if (obs !== exp) begin n_fail++; $display("FAIL rand_beat it %0d beat %0d req %h/%h: got %b expected %b", it, k, a, m, obs, exp); end
                    m_beats++;
                    @(negedge clk);
                end
            end
            n_checks++;
            if (obs !== IDLE_OBS) begin n_fail++; $display("FAIL rand_idle it %0d: got %b expected %b", it, obs, IDLE_OBS); end
        end
`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
        n_checks++;
        if (stat_beats !== m_beats) begin n_fail++; $display("FAIL rand_stat_beats: got %0d expected %0d", stat_beats, m_beats); end
        n_checks++;
        if (stat_errs !== m_errs) begin n_fail++; $display("FAIL rand_stat_errs: got %0d expected %0d", stat_errs, m_errs); end
`endif
        set_default_map();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = 8'h00; req_mask = 8'h00; mst_ready = 1'b0;
        set_default_map();
        test_reset();
        test_unicast();
        test_multicast(0);
        test_multicast(3);
        test_no_match();
        test_reset_mid();
`ifdef MULTIADDR_REQ_SCHEDULER_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
